excep_ctrl: RTL and testbench
=============================

EXCEP_CTRL -- requirements
Module: excep_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 mem_valid_i  in  1  MEM-stage slot holds a live instruction.
REQ-004 mem_pc_i  in  32  PC of MEM-stage instruction.
REQ-005 mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
REQ-006 mem_excep_i  in  8  raw flags: [7] fetch AdEL, [6] RI, [5] Ov, [4] Bp, [3] Sys, [2] load AdEL, [1] store AdES, [0] ERET.
REQ-007 mem_addr_i  in  32  data address of the MEM-stage load/store.
REQ-008 cp0_flush_i  in  1  registered flush from CP0.
REQ-009 cp0_return_pc_i  in  32  redirect target from CP0, valid with cp0_flush_i.
REQ-010 redirect_ready_i  in  1  fetch unit accepts the redirect this cycle.
REQ-011 exception_type_o  out  32  CP0 exception vector: [31] fetch AdEL, [30] RI, [29] Ov, [28] Bp, [27] Sys, [26] load AdEL, [25] store AdES, [0] ERET; all other bits 0.
REQ-012 exception_addr_o  out  32  bad address to CP0.
REQ-013 pc_o  out  32  faulting PC to CP0.
REQ-014 in_delayslot_o  out  1  delay-slot flag to CP0.
REQ-015 mem_kill_o  out  1  suppresses the MEM-stage store and register writeback.
REQ-016 flush_all_o  out  1  one-cycle flush of the IF/ID/EX/MEM pipeline registers.
REQ-017 redirect_valid_o  out  1  redirect request to fetch.
REQ-018 redirect_pc_o  out  32  redirect target.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_CP0 and REDIRECT.
REQ-020 In IDLE, when mem_valid_i=1 and mem_excep_i!=0, exception_type_o SHALL map the flags combinationally per REQ-006/REQ-011; otherwise it SHALL be 0.
REQ-021 exception_addr_o SHALL be mem_pc_i when mem_excep_i[7]=1, otherwise mem_addr_i.
REQ-022 pc_o SHALL equal mem_pc_i and in_delayslot_o SHALL equal mem_in_delayslot_i combinationally.
REQ-023 mem_kill_o SHALL be 1 in the same cycle as a nonzero exception_type_o, except for ERET alone, and 1 in every WAIT_CP0 and REDIRECT cycle.
REQ-024 IDLE -> WAIT_CP0 SHALL occur on any cycle with nonzero exception_type_o.
REQ-025 In WAIT_CP0, when cp0_flush_i=1, the block SHALL latch cp0_return_pc_i into redirect_pc_o, pulse flush_all_o, and go to REDIRECT.
REQ-026 In WAIT_CP0, when cp0_flush_i=0 (nested exception, EXL already 1), the block SHALL return to IDLE with no flush and no redirect.
REQ-027 In IDLE, cp0_flush_i=1 with no exception presented (interrupt or timer) SHALL be handled as in REQ-025.
REQ-028 In REDIRECT, redirect_valid_o=1 and redirect_pc_o SHALL hold stable until redirect_ready_i=1; in that same cycle the FSM SHALL go to IDLE.
REQ-029 exception_type_o SHALL be forced to 0 in WAIT_CP0 and REDIRECT.
REQ-030 A cp0_flush_i pulse arriving in REDIRECT SHALL overwrite redirect_pc_o, re-pulse flush_all_o, and keep the state REDIRECT.
REQ-031 flush_all_o SHALL be asserted for exactly one cycle per accepted cp0_flush_i.
REQ-032 The minimum exception-to-redirect latency SHALL be 2 cycles: detect at N, flush_all_o at N+1, redirect_valid_o from N+2.

Reset
REQ-033 On rst, the state SHALL be IDLE, redirect_pc_o 32'h0, redirect_valid_o 0, flush_all_o 0, and mem_kill_o 0.
REQ-034 A reset during WAIT_CP0 or REDIRECT SHALL abandon the pending redirect, with no flush pulse on the next cycle.

Structure
REQ-035 The exception-bit indices, EXCEP_TYPE_BUS width and FSM state encodings SHALL live in the shared defines.vh.
REQ-036 The block SHALL be a single module; the flag-to-vector mapping MAY be a sub-module excep_encode (combinational).

Verification
REQ-037 Sys at mem_pc 0x8000_1000 with no delay slot -> exception_type_o=0x0800_0000, mem_kill_o=1; cp0_flush_i with 0xbfc0_0380 at N+1 -> flush_all_o pulse; redirect_valid_o at N+2 with pc 0xbfc0_0380.
REQ-038 Store AdES, addr 0x0000_0003, pc 0x8000_2004 in delay slot -> exception_type_o=0x0200_0000, exception_addr_o=0x0000_0003, in_delayslot_o=1.
REQ-039 Fetch AdEL together with Ov -> bits 31 and 29 both set; exception_addr_o=mem_pc_i.
REQ-040 Exception with no cp0_flush_i at N+1 -> back to IDLE at N+2; no flush_all_o, no redirect_valid_o.
REQ-041 redirect_ready_i held 0 for 5 cycles -> redirect_valid_o and redirect_pc_o stable; a new exception presented meanwhile -> exception_type_o=0.
REQ-042 Interrupt flush in IDLE, then rst asserted during REDIRECT -> outputs at reset values on the next cycle.

Source files
------------

// File: rtl/excep_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller: vector bit
// positions, bus width and FSM state encodings.
package excep_ctrl_pkg;
  localparam int EXCEP_TYPE_W = 32;

  localparam int EXC_FETCH_ADEL = 31;
  localparam int EXC_RI         = 30;
  localparam int EXC_OV         = 29;
  localparam int EXC_BP         = 28;
  localparam int EXC_SYS        = 27;
  localparam int EXC_LOAD_ADEL  = 26;
  localparam int EXC_STORE_ADES = 25;
  localparam int EXC_ERET       = 0;

  // An ERET on its own still enters CP0 but must let the instruction retire.
  localparam logic [EXCEP_TYPE_W-1:0] ERET_ONLY = EXCEP_TYPE_W'(1) << EXC_ERET;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CP0 = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;
endpackage

// File: rtl/excep_ctrl_encode.sv
// Maps the raw MEM-stage flag byte onto the CP0 exception vector layout.
module excep_ctrl_encode
  import excep_ctrl_pkg::*;
(
  input  logic [7:0]              flags,
  output logic [EXCEP_TYPE_W-1:0] vec
);
  always_comb begin
    vec                 = '0;
    vec[EXC_FETCH_ADEL] = flags[7];
    vec[EXC_RI]         = flags[6];
    vec[EXC_OV]         = flags[5];
    vec[EXC_BP]         = flags[4];
    vec[EXC_SYS]        = flags[3];
    vec[EXC_LOAD_ADEL]  = flags[2];
    vec[EXC_STORE_ADES] = flags[1];
    vec[EXC_ERET]       = flags[0];
  end
endmodule

// File: rtl/excep_ctrl.sv
// MEM-stage exception controller: reports exceptions to CP0, turns the CP0
// flush into a pipeline flush plus a held fetch redirect.
module excep_ctrl
  import excep_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid_i,
  input  logic [31:0]             mem_pc_i,
  input  logic                    mem_in_delayslot_i,
  input  logic [7:0]              mem_excep_i,
  input  logic [31:0]             mem_addr_i,
  input  logic                    cp0_flush_i,
  input  logic [31:0]             cp0_return_pc_i,
  input  logic                    redirect_ready_i,
  output logic [EXCEP_TYPE_W-1:0] exception_type_o,
  output logic [31:0]             exception_addr_o,
  output logic [31:0]             pc_o,
  output logic                    in_delayslot_o,
  output logic                    mem_kill_o,
  output logic                    flush_all_o,
  output logic                    redirect_valid_o,
  output logic [31:0]             redirect_pc_o
);
  state_t state, state_nxt;
  logic [EXCEP_TYPE_W-1:0] enc_vec;
  logic                    excep_hit;

  excep_ctrl_encode u_enc (.flags(mem_excep_i), .vec(enc_vec));

  assign excep_hit        = (state == ST_IDLE) && mem_valid_i && (enc_vec != '0);
  assign exception_addr_o = mem_excep_i[7] ? mem_pc_i : mem_addr_i;
  assign pc_o             = mem_pc_i;
  assign in_delayslot_o   = mem_in_delayslot_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      redirect_pc_o <= 32'h0;
    end else begin
      state <= state_nxt;
      if (flush_all_o) redirect_pc_o <= cp0_return_pc_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (excep_hit) state_nxt = ST_WAIT_CP0;
                   else if (cp0_flush_i) state_nxt = ST_REDIRECT;
      // No flush here means CP0 already had EXL set: drop the exception quietly.
      ST_WAIT_CP0: state_nxt = cp0_flush_i ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: if (!cp0_flush_i && redirect_ready_i) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    exception_type_o = excep_hit ? enc_vec : '0;
    redirect_valid_o = (state == ST_REDIRECT);
    mem_kill_o       = 1'b0;
    flush_all_o      = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_kill_o  = excep_hit && (enc_vec != ERET_ONLY);
        // A flush coinciding with a fresh exception defers to the exception.
        flush_all_o = cp0_flush_i && !excep_hit && !rst;
      end
      ST_WAIT_CP0, ST_REDIRECT: begin
        mem_kill_o  = 1'b1;
        flush_all_o = cp0_flush_i && !rst;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_excep_ctrl.sv
// Directed bench for excep_ctrl: table of IDLE-state vectors plus hand-written
// multi-cycle sequences for flush, redirect hold, nesting and reset.
module tb_excep_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [7:0]  mem_excep_i;
  logic [31:0] mem_addr_i;
  logic        cp0_flush_i;
  logic [31:0] cp0_return_pc_i;
  logic        redirect_ready_i;
  logic [31:0] exception_type_o;
  logic [31:0] exception_addr_o;
  logic [31:0] pc_o;
  logic        in_delayslot_o;
  logic        mem_kill_o;
  logic        flush_all_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int checks = 0;
  int errors = 0;

  excep_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_excep_i(mem_excep_i),
    .mem_addr_i(mem_addr_i), .cp0_flush_i(cp0_flush_i),
    .cp0_return_pc_i(cp0_return_pc_i), .redirect_ready_i(redirect_ready_i),
    .exception_type_o(exception_type_o), .exception_addr_o(exception_addr_o),
    .pc_o(pc_o), .in_delayslot_o(in_delayslot_o), .mem_kill_o(mem_kill_o),
    .flush_all_o(flush_all_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_ctl(input string tag, input logic kill, input logic fl,
                         input logic rv, input logic [31:0] rpc);
    chk({tag, ".kill"},  {31'h0, mem_kill_o},       {31'h0, kill});
    chk({tag, ".flush"}, {31'h0, flush_all_o},      {31'h0, fl});
    chk({tag, ".rvld"},  {31'h0, redirect_valid_o}, {31'h0, rv});
    chk({tag, ".rpc"},   redirect_pc_o,             rpc);
  endtask

  task automatic idle_inputs();
    mem_valid_i = 1'b0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0;
    mem_excep_i = 8'h0; mem_addr_i = 32'h0; cp0_flush_i = 1'b0;
    cp0_return_pc_i = 32'h0; redirect_ready_i = 1'b0;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [7:0]  excep;
    logic [31:0] addr;
    logic [31:0] exp_type;
    logic [31:0] exp_addr;
    logic        exp_kill;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{1'b1, 32'h8000_1000, 1'b0, 8'h08, 32'h0000_1234, 32'h0800_0000, 32'h0000_1234, 1'b1};
    tv[1] = '{1'b1, 32'h8000_2004, 1'b1, 8'h02, 32'h0000_0003, 32'h0200_0000, 32'h0000_0003, 1'b1};
    tv[2] = '{1'b1, 32'h8000_3001, 1'b0, 8'hA0, 32'h0000_0055, 32'hA000_0000, 32'h8000_3001, 1'b1};
    tv[3] = '{1'b1, 32'h8000_4000, 1'b0, 8'h01, 32'h0000_0010, 32'h0000_0001, 32'h0000_0010, 1'b0};
    tv[4] = '{1'b0, 32'h8000_5000, 1'b1, 8'h40, 32'h0000_0020, 32'h0000_0000, 32'h0000_0020, 1'b0};
    tv[5] = '{1'b1, 32'h8000_6000, 1'b0, 8'h00, 32'h0000_0030, 32'h0000_0000, 32'h0000_0030, 1'b0};
    tv[6] = '{1'b1, 32'h8000_7000, 1'b0, 8'h40, 32'h0000_0040, 32'h4000_0000, 32'h0000_0040, 1'b1};
    tv[7] = '{1'b1, 32'h8000_8000, 1'b1, 8'h10, 32'h0000_0050, 32'h1000_0000, 32'h0000_0050, 1'b1};
    tv[8] = '{1'b1, 32'h8000_9000, 1'b0, 8'h04, 32'h0000_0061, 32'h0400_0000, 32'h0000_0061, 1'b1};
    tv[9] = '{1'b1, 32'h8000_A000, 1'b0, 8'hFF, 32'h0000_0070, 32'hFE00_0001, 32'h8000_A000, 1'b1};

    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sample();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.type", exception_type_o, 32'h0);

    // IDLE vectors; any detected exception goes to WAIT_CP0 and, with no
    // CP0 flush, comes back to IDLE one cycle later.
    for (int i = 0; i < 10; i++) begin
      step();
      mem_valid_i = tv[i].valid; mem_pc_i = tv[i].pc; mem_in_delayslot_i = tv[i].ds;
      mem_excep_i = tv[i].excep; mem_addr_i = tv[i].addr;
      sample();
      chk($sformatf("v%0d.type", i), exception_type_o, tv[i].exp_type);
      chk($sformatf("v%0d.addr", i), exception_addr_o, tv[i].exp_addr);
      chk($sformatf("v%0d.pc", i), pc_o, tv[i].pc);
      chk($sformatf("v%0d.ds", i), {31'h0, in_delayslot_o}, {31'h0, tv[i].ds});
      chk($sformatf("v%0d.kill", i), {31'h0, mem_kill_o}, {31'h0, tv[i].exp_kill});
      chk($sformatf("v%0d.flush", i), {31'h0, flush_all_o}, 32'h0);
      step();
      idle_inputs();
      sample();
      chk_ctl($sformatf("v%0d.wait", i), tv[i].exp_type != 0, 1'b0, 1'b0, 32'h0);
      step();
      sample();
      chk_ctl($sformatf("v%0d.back", i), 1'b0, 1'b0, 1'b0, 32'h0);
    end

    // Sys -> CP0 flush at N+1 -> redirect from N+2, held while not ready.
    step();
    mem_valid_i = 1'b1; mem_pc_i = 32'h8000_1000; mem_excep_i = 8'h08;
    sample();
    chk("sys.type", exception_type_o, 32'h0800_0000);
    chk("sys.kill", {31'h0, mem_kill_o}, 32'h1);
    step();
    idle_inputs();
    cp0_flush_i = 1'b1; cp0_return_pc_i = 32'hbfc0_0380;
    sample();
    chk_ctl("sys.n1", 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    cp0_flush_i = 1'b0; cp0_return_pc_i = 32'h0;
    mem_valid_i = 1'b1; mem_excep_i = 8'h20; mem_pc_i = 32'h8000_1100;
    sample();
    chk_ctl("sys.n2", 1'b1, 1'b0, 1'b1, 32'hbfc0_0380);
    chk("sys.n2.type", exception_type_o, 32'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      sample();
      chk_ctl($sformatf("hold%0d", c), 1'b1, 1'b0, 1'b1, 32'hbfc0_0380);
      chk($sformatf("hold%0d.type", c), exception_type_o, 32'h0);
    end
    step();
    idle_inputs();
    redirect_ready_i = 1'b1;
    sample();
    chk_ctl("accept", 1'b1, 1'b0, 1'b1, 32'hbfc0_0380);
    step();
    redirect_ready_i = 1'b0;
    sample();
    chk_ctl("accept.idle", 1'b0, 1'b0, 1'b0, 32'hbfc0_0380);

    // Interrupt flush in IDLE, re-flush while redirecting, then reset.
    step();
    cp0_flush_i = 1'b1; cp0_return_pc_i = 32'h8000_0180;
    sample();
    chk_ctl("irq.n0", 1'b0, 1'b1, 1'b0, 32'hbfc0_0380);
    step();
    cp0_flush_i = 1'b0;
    sample();
    chk_ctl("irq.n1", 1'b1, 1'b0, 1'b1, 32'h8000_0180);
    step();
    cp0_flush_i = 1'b1; cp0_return_pc_i = 32'hbfc0_0200; redirect_ready_i = 1'b1;
    sample();
    chk_ctl("reflush", 1'b1, 1'b1, 1'b1, 32'h8000_0180);
    step();
    cp0_flush_i = 1'b0; redirect_ready_i = 1'b0;
    sample();
    chk_ctl("reflush.n1", 1'b1, 1'b0, 1'b1, 32'hbfc0_0200);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk_ctl("rst.redir", 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset while waiting on CP0 drops the exception without a flush.
    step();
    mem_valid_i = 1'b1; mem_excep_i = 8'h10; mem_pc_i = 32'h8000_2200;
    step();
    idle_inputs();
    rst = 1'b1;
    sample();
    chk("rst.wait.kill", {31'h0, mem_kill_o}, 32'h1);
    step();
    rst = 1'b0;
    sample();
    chk_ctl("rst.wait", 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    sample();
    chk_ctl("rst.wait.n1", 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
